// File: rtl/autotype_sequencer.sv
// autotype_sequencer: scripted reset/keystroke scheduler for button-less boards.
// Walks a table of {action, duration} entries and drives the computer's n_reset
// and onboard key inputs with tick-accurate timing.
//
// state | meaning
// IDLE  | outputs released, waiting for start
// LOAD  | one cycle: decode SCRIPT[step], previous outputs still held
// RUN   | holding the current entry's outputs for duration * TICK_DIV cycles
// DONE  | script finished, outputs released, done high, step frozen
module autotype_sequencer #(
  parameter int unsigned        TICK_DIV  = 32'd4194304,
  parameter int unsigned        STEPS     = 12,
  parameter logic [8*STEPS-1:0] SCRIPT    = {8'hE0, 8'h82, 8'h04, 8'h82, 8'h02, 8'h82,
                                             8'h02, 8'h62, 8'h02, 8'h42, 8'h04, 8'h24},
  parameter bit                 AUTOSTART = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       cpu_n_reset,
  output logic       key_b,
  output logic       key_c,
  output logic       key_enter,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [3:0]    STEP_LAST = 4'(STEPS - 1);

  localparam logic [2:0] ACT_RESET = 3'd1;
  localparam logic [2:0] ACT_KEY_B = 3'd2;
  localparam logic [2:0] ACT_KEY_C = 3'd3;
  localparam logic [2:0] ACT_ENTER = 3'd4;
  localparam logic [2:0] ACT_END   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    ticks_q, ticks_d;
  logic [3:0]    step_q, step_d;
  logic          n_reset_q, n_reset_d;
  logic          key_b_q, key_b_d;
  logic          key_c_q, key_c_d;
  logic          key_enter_q, key_enter_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    entry;
  logic [2:0]    act;
  logic [4:0]    dur;

  // Pick the script entry addressed by the current step.
  always_comb begin
    entry = 8'h00;
    for (int i = 0; i < STEPS; i++) begin
      if (step_q == 4'(i)) entry = SCRIPT[8*i +: 8];
    end
  end

  assign act = entry[7:5];
  assign dur = entry[4:0];

  // Next-state and next-output logic; abort overrides everything else.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    ticks_d     = ticks_q;
    step_d      = step_q;
    n_reset_d   = n_reset_q;
    key_b_d     = key_b_q;
    key_c_d     = key_c_q;
    key_enter_d = key_enter_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE: begin
        n_reset_d   = 1'b1;
        key_b_d     = 1'b0;
        key_c_d     = 1'b0;
        key_enter_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        if (start) begin
          step_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (act == ACT_END) begin
          n_reset_d   = 1'b1;
          key_b_d     = 1'b0;
          key_c_d     = 1'b0;
          key_enter_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
          // Unlisted actions (0, 5, 6) fall out as a gap: everything released.
          n_reset_d   = (act != ACT_RESET);
          key_b_d     = (act == ACT_KEY_B);
          key_c_d     = (act == ACT_KEY_C);
          key_enter_d = (act == ACT_ENTER);
          ticks_d     = (dur == 5'd0) ? 5'd1 : dur;
          presc_d     = '0;
          busy_d      = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (presc_q == PRE_LAST) begin
          presc_d = '0;
          ticks_d = ticks_q - 5'd1;
          if (ticks_q == 5'd1) begin
            if (step_q == STEP_LAST) begin
              n_reset_d   = 1'b1;
              key_b_d     = 1'b0;
              key_c_d     = 1'b0;
              key_enter_d = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              state_d     = S_DONE;
            end else begin
              step_d  = step_q + 4'd1;
              state_d = S_LOAD;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_DONE: begin
        n_reset_d   = 1'b1;
        key_b_d     = 1'b0;
        key_c_d     = 1'b0;
        key_enter_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        if (start) begin
          step_d  = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d     = S_IDLE;
      step_d      = 4'd0;
      n_reset_d   = 1'b1;
      key_b_d     = 1'b0;
      key_c_d     = 1'b0;
      key_enter_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end

  // Register state, counters and outputs; reset parks the computer in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= AUTOSTART ? S_LOAD : S_IDLE;
      presc_q     <= '0;
      ticks_q     <= 5'd0;
      step_q      <= 4'd0;
      n_reset_q   <= 1'b0;
      key_b_q     <= 1'b0;
      key_c_q     <= 1'b0;
      key_enter_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ticks_q     <= ticks_d;
      step_q      <= step_d;
      n_reset_q   <= n_reset_d;
      key_b_q     <= key_b_d;
      key_c_q     <= key_c_d;
      key_enter_q <= key_enter_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cpu_n_reset = n_reset_q;
  assign key_b       = key_b_q;
  assign key_c       = key_c_q;
  assign key_enter   = key_enter_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step        = step_q;

endmodule
